// File: rtl/lzrw1_stream_decompressor_if.sv
// Item-in / byte-out stream bus for the LZRW1 decompressor.
interface lzrw1_stream_decompressor_if #(
  parameter int ITEM_W = 16
) ();
  logic [ITEM_W-1:0] in_data;
  logic              in_ctrl;
  logic              in_last;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        out_data;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  in_data, in_ctrl, in_last, in_valid, out_ready,
    output in_ready, out_data, out_last, out_valid
  );

  modport master (
    output in_data, in_ctrl, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_last, out_valid
  );
endinterface

// File: rtl/lzrw1_stream_decompressor.sv
// LZRW1 stream decompressor: literals pass straight through, copy items
// replay bytes from a circular history buffer, one byte per cycle.
module lzrw1_stream_decompressor #(
  parameter int HISTORY_SIZE = 4096,
  parameter int OFFSET_WIDTH = 12,
  parameter int LEN_WIDTH    = 4,
  parameter int MIN_MATCH    = 3
) (
  input  logic clock,
  input  logic reset,
  lzrw1_stream_decompressor_if.slave bus,
  output logic error
);
  localparam int PTR_W = $clog2(HISTORY_SIZE);
  localparam int FC_W  = PTR_W + 1;
  localparam int REM_W = $clog2((1 << LEN_WIDTH) + MIN_MATCH) + 1;

  typedef enum logic {IDLE, COPY} state_t;

  state_t           state_q, state_d;
  logic [7:0]       hist_q [HISTORY_SIZE];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] src_q, src_d;
  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             last_q, last_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             error_q, error_d;

  logic                    can_load, accept, illegal, produce, prod_last;
  logic [7:0]              prod_byte;
  logic [OFFSET_WIDTH-1:0] off;
  logic [LEN_WIDTH-1:0]    lenf;

  // The output register may take a new byte when empty or draining this edge.
  assign can_load     = !out_valid_q || bus.out_ready;
  assign bus.in_ready = reset && (state_q == IDLE) && can_load;
  assign accept       = bus.in_valid && bus.in_ready;
  assign off          = bus.in_data[OFFSET_WIDTH-1:0];
  assign lenf         = bus.in_data[OFFSET_WIDTH +: LEN_WIDTH];
  // A copy may only reach back into bytes of the current frame.
  assign illegal      = (off == '0) || (FC_W'(off) > frame_cnt_q);

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign error         = error_q;

  // Next-state: item decode, copy sequencing, output register and counters.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    rem_d       = rem_q;
    last_d      = last_q;
    wr_ptr_d    = wr_ptr_q;
    frame_cnt_d = frame_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    error_d     = error_q;
    produce     = 1'b0;
    prod_byte   = 8'h00;
    prod_last   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!bus.in_ctrl) begin
            produce   = 1'b1;
            prod_byte = bus.in_data[7:0];
            prod_last = bus.in_last;
          end else if (illegal) begin
            error_d = 1'b1;
            // A dropped final copy still closes the frame.
            if (bus.in_last) frame_cnt_d = '0;
          end else begin
            src_d   = wr_ptr_q - PTR_W'(off);
            rem_d   = REM_W'(lenf) + REM_W'(MIN_MATCH);
            last_d  = bus.in_last;
            state_d = COPY;
          end
        end
      end
      COPY: begin
        if (can_load) begin
          // History read sees bytes written on earlier edges, so overlapping
          // copies naturally replicate freshly produced bytes.
          produce   = 1'b1;
          prod_byte = hist_q[src_q];
          prod_last = last_q && (rem_q == REM_W'(1));
          src_d     = src_q + PTR_W'(1);
          rem_d     = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (produce) begin
      out_valid_d = 1'b1;
      out_data_d  = prod_byte;
      out_last_d  = prod_last;
      wr_ptr_d    = wr_ptr_q + PTR_W'(1);
      if (prod_last)                              frame_cnt_d = '0;
      else if (frame_cnt_q != FC_W'(HISTORY_SIZE)) frame_cnt_d = frame_cnt_q + FC_W'(1);
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      src_q       <= '0;
      rem_q       <= '0;
      last_q      <= 1'b0;
      wr_ptr_q    <= '0;
      frame_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= 8'h00;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      rem_q       <= rem_d;
      last_q      <= last_d;
      wr_ptr_q    <= wr_ptr_d;
      frame_cnt_q <= frame_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      error_q     <= error_d;
    end
  end

  // History RAM: every produced byte is recorded; contents survive reset.
  always_ff @(posedge clock) begin
    if (produce) hist_q[wr_ptr_q] <= prod_byte;
  end
endmodule

// File: doc/lzrw1_stream_decompressor.md
LZRW1_STREAM_DECOMPRESSOR -- requirements
Module: lzrw1_stream_decompressor

Interface
REQ-001 Parameter HISTORY_SIZE, default 4096; history buffer depth in bytes, power of two, SHALL be >= 2**OFFSET_WIDTH.
REQ-002 Parameter OFFSET_WIDTH, default 12; copy-item offset field width.
REQ-003 Parameter LEN_WIDTH, default 4; copy-item length field width.
REQ-004 Parameter MIN_MATCH, default 3; copy length = length field + MIN_MATCH.
REQ-005 clock  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 in_data  in  LEN_WIDTH+OFFSET_WIDTH  item; copy: [MSBs]=length field, [OFFSET_WIDTH-1:0]=offset; literal: [7:0]=byte, upper bits ignored.
REQ-008 in_ctrl  in  1  control-word bit for item; 0=literal, 1=copy.
REQ-009 in_last  in  1  item is the last of its frame.
REQ-010 in_valid  in  1  item valid.
REQ-011 in_ready  out  1  block accepts item this cycle.
REQ-012 out_data  out  8  decompressed byte.
REQ-013 out_last  out  1  out_data is final byte of frame.
REQ-014 out_valid  out  1  out_data valid.
REQ-015 out_ready  in  1  downstream accepts byte.
REQ-016 error  out  1  sticky illegal-copy flag.

Function
REQ-017 Item accepted on rising edge with in_valid & in_ready; byte transferred on rising edge with out_valid & out_ready.
REQ-018 out_valid/out_data/out_last held stable while out_valid & !out_ready.
REQ-019 FSM states IDLE, COPY; in_ready = (state==IDLE) & (!out_valid | out_ready).
REQ-020 A byte is "produced" when loaded into the output register; allowed only when !out_valid | out_ready; same edge writes it to history[wr_ptr], increments wr_ptr mod HISTORY_SIZE and frame_count (saturating at HISTORY_SIZE).
REQ-021 Literal accept in IDLE: byte produced on accepting edge; out_valid high the following cycle; state stays IDLE; out_last = in_last.
REQ-022 Copy accept in IDLE, legal: src = (wr_ptr - offset) mod HISTORY_SIZE, remaining = length; state -> COPY; no byte produced on accepting edge.
REQ-023 COPY: each edge allowed by REQ-020 produces history[src] (combinational read of current contents), src+1 mod HISTORY_SIZE, remaining-1; last byte carries captured in_last; remaining reaches 0 -> IDLE.
REQ-024 Overlapping copies (offset < length) SHALL replicate bytes produced earlier in the same copy (offset 1 repeats one byte).
REQ-025 Copy illegal if offset==0 or offset > frame_count; illegal copy produces no bytes, sets error, state stays IDLE; if in_last set, frame ends with no extra out_last byte.
REQ-026 Once error is set, it stays set until reset; decoding continues.
REQ-027 After production of a byte with out_last, frame_count SHALL clear to 0 on the same edge; history contents are not cleared.
REQ-028 Throughput: one byte per cycle with out_ready held high; copy of length L occupies L+1 cycles from accept to return to IDLE-ready.
REQ-029 wr_ptr and src wrap modulo HISTORY_SIZE with no bubble.

Reset
REQ-030 reset low asynchronously forces: state IDLE, out_valid 0, out_last 0, out_data 0x00, error 0, wr_ptr 0, frame_count 0, remaining 0.
REQ-031 in_ready SHALL be 0 while reset is low; reset mid-COPY abandons remaining bytes, no further output after release.
REQ-032 History RAM contents need not be reset.

Verification
REQ-033 Literals 'a','b','c' (in_ctrl=0), out_ready=1 -> out_data 0x61,0x62,0x63 on consecutive cycles, error 0.
REQ-034 Literals 'a','b', copy length field 3, offset 2 -> "ab" then "ababab" (6 copied bytes), 8 bytes total.
REQ-035 Literal 'x', copy length field 0, offset 1, in_last=1 -> "xxxx", out_last high only on byte 4, frame_count returns to 0.
REQ-036 Repeat REQ-034 with out_ready toggled randomly -> identical byte sequence, no drop/duplicate, outputs stable while stalled.
REQ-037 First item of frame is copy with offset 1 -> error rises, no bytes output; subsequent literal 'z' still produced.
REQ-038 Reset asserted during 16-byte copy -> out_valid 0 immediately; after release, literal 'q' produces exactly 0x71.
